// File: rtl/sort_pkg.sv
// Shared types for the sort-engine arbiter: FSM state encoding and default data width.
package sort_pkg;

    localparam int unsigned DWIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE_S   = 2'd0,
        FEED_S   = 2'd1,
        RESULT_S = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr_i, wrapping modulo N_REQ.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             any_grant_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant_o     = '0;
        any_grant_o = 1'b0;
        idx         = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = IDX_W'((32'(ptr_i) + i) % N_REQ);
            if (!any_grant_o && req_i[idx]) begin
                any_grant_o = 1'b1;
                grant_o     = idx;
            end
        end
    end

endmodule

// File: rtl/sort_arbiter.sv
// Packet-granular round-robin scheduler sharing one sort engine between N_REQ Avalon-ST
// requesters: feeds the granted packet in, then routes the sorted packet back to the same owner.
module sort_arbiter
    import sort_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DWIDTH = DWIDTH_DEFAULT,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic [N_REQ*DWIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]        req_startofpacket_i,
    input  logic [N_REQ-1:0]        req_endofpacket_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [DWIDTH-1:0]       eng_data_o,
    output logic                    eng_startofpacket_o,
    output logic                    eng_endofpacket_o,
    output logic                    eng_valid_o,
    input  logic                    eng_ready_i,
    input  logic [DWIDTH-1:0]       eng_data_i,
    input  logic                    eng_startofpacket_i,
    input  logic                    eng_endofpacket_i,
    input  logic                    eng_valid_i,
    output logic                    eng_ready_o,
    output logic [DWIDTH-1:0]       res_data_o,
    output logic                    res_startofpacket_o,
    output logic                    res_endofpacket_o,
    output logic [N_REQ-1:0]        res_valid_o,
    input  logic [N_REQ-1:0]        res_ready_i,
    output logic [IDX_W-1:0]        owner_o,
    output logic                    busy_o,
    output logic [15:0]             drop_cnt_o
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [15:0]      drop_q, drop_d;

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] stray;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] pick;
    logic             pick_vld;
    logic [DWIDTH-1:0] owner_data;

    always_comb begin
        eligible   = req_valid_i & req_startofpacket_i;
        stray      = req_valid_i & ~req_startofpacket_i;
        ptr        = (last_q == IDX_W'(N_REQ - 1)) ? '0 : last_q + 1'b1;
        owner_data = req_data_i[32'(owner_q) * DWIDTH +: DWIDTH];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i       (eligible),
        .ptr_i       (ptr),
        .grant_o     (pick),
        .any_grant_o (pick_vld)
    );

    always_comb begin
        state_d             = state_q;
        owner_d             = owner_q;
        last_d              = last_q;
        drop_d              = drop_q;
        req_ready_o         = '0;
        eng_data_o          = '0;
        eng_startofpacket_o = 1'b0;
        eng_endofpacket_o   = 1'b0;
        eng_valid_o         = 1'b0;
        eng_ready_o         = 1'b0;
        res_data_o          = '0;
        res_startofpacket_o = 1'b0;
        res_endofpacket_o   = 1'b0;
        res_valid_o         = '0;

        unique case (state_q)
            IDLE_S: begin
                // Beats without SOP cannot start a packet; swallow them so they do not block.
                req_ready_o = stray;
                if (|stray && drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
                if (pick_vld) begin
                    owner_d = pick;
                    state_d = FEED_S;
                end
            end
            FEED_S: begin
                eng_valid_o          = req_valid_i[owner_q];
                req_ready_o[owner_q] = eng_ready_i;
                if (eng_valid_o) begin
                    eng_data_o          = owner_data;
                    eng_startofpacket_o = req_startofpacket_i[owner_q];
                    eng_endofpacket_o   = req_endofpacket_i[owner_q];
                    if (eng_ready_i && req_endofpacket_i[owner_q]) begin
                        state_d = RESULT_S;
                    end
                end
            end
            RESULT_S: begin
                res_valid_o[owner_q] = eng_valid_i;
                eng_ready_o          = res_ready_i[owner_q];
                if (eng_valid_i) begin
                    res_data_o          = eng_data_i;
                    res_startofpacket_o = eng_startofpacket_i;
                    res_endofpacket_o   = eng_endofpacket_i;
                    if (eng_ready_o && eng_endofpacket_i) begin
                        state_d = IDLE_S;
                        last_d  = owner_q;
                    end
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE_S;
            owner_q <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
        end
    end

    assign owner_o    = owner_q;
    assign busy_o     = (state_q != IDLE_S);
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_sort_arbiter.sv
// Scoreboard bench for sort_arbiter: requester/engine agents plus expected-result queues.
module tb_sort_arbiter;

    typedef struct {
        int         k;
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    logic        clk_i = 1'b0;
    logic        arstn_i = 1'b0;
    logic [31:0] req_data_i = '0;
    logic [3:0]  req_startofpacket_i = '0;
    logic [3:0]  req_endofpacket_i = '0;
    logic [3:0]  req_valid_i = '0;
    logic [3:0]  req_ready_o;
    logic [7:0]  eng_data_o;
    logic        eng_startofpacket_o;
    logic        eng_endofpacket_o;
    logic        eng_valid_o;
    logic        eng_ready_i = 1'b0;
    logic [7:0]  eng_data_i = '0;
    logic        eng_startofpacket_i = 1'b0;
    logic        eng_endofpacket_i = 1'b0;
    logic        eng_valid_i = 1'b0;
    logic        eng_ready_o;
    logic [7:0]  res_data_o;
    logic        res_startofpacket_o;
    logic        res_endofpacket_o;
    logic [3:0]  res_valid_o;
    logic [3:0]  res_ready_i = '0;
    logic [1:0]  owner_o;
    logic        busy_o;
    logic [15:0] drop_cnt_o;

    sort_arbiter #(
        .N_REQ  (4),
        .DWIDTH (8)
    ) dut (
        .clk_i               (clk_i),
        .arstn_i             (arstn_i),
        .req_data_i          (req_data_i),
        .req_startofpacket_i (req_startofpacket_i),
        .req_endofpacket_i   (req_endofpacket_i),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .eng_data_o          (eng_data_o),
        .eng_startofpacket_o (eng_startofpacket_o),
        .eng_endofpacket_o   (eng_endofpacket_o),
        .eng_valid_o         (eng_valid_o),
        .eng_ready_i         (eng_ready_i),
        .eng_data_i          (eng_data_i),
        .eng_startofpacket_i (eng_startofpacket_i),
        .eng_endofpacket_i   (eng_endofpacket_i),
        .eng_valid_i         (eng_valid_i),
        .eng_ready_o         (eng_ready_o),
        .res_data_o          (res_data_o),
        .res_startofpacket_o (res_startofpacket_o),
        .res_endofpacket_o   (res_endofpacket_o),
        .res_valid_o         (res_valid_o),
        .res_ready_i         (res_ready_i),
        .owner_o             (owner_o),
        .busy_o              (busy_o),
        .drop_cnt_o          (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    beat_t      tx_q[$];
    beat_t      exp_res_q[$];
    beat_t      eng_out_q[$];
    int         exp_owner_q[$];
    logic [7:0] pkt_buf[$];

    logic bp = 1'b0;
    logic tog = 1'b0;
    int   stall_left = 0;
    int   stray_cnt = 0;
    logic feeding = 1'b0;
    int   cur_owner = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_idx(input int k);
        int r = -1;
        for (int i = 0; i < tx_q.size(); i++) begin
            if (r < 0 && tx_q[i].k == k) r = i;
        end
        return r;
    endfunction

    // Queue a packet on requester req and push its sorted result and expected grant.
    task automatic queue_pkt(input int req, input int n, input logic [31:0] words);
        logic [7:0] s[4];
        logic [7:0] t;
        beat_t      b;
        for (int i = 0; i < 4; i++) s[i] = '0;
        for (int i = 0; i < n; i++) begin
            s[i]  = words[i*8 +: 8];
            b.k   = req;
            b.d   = s[i];
            b.sop = (i == 0);
            b.eop = (i == n - 1);
            tx_q.push_back(b);
        end
        for (int a = 0; a < n - 1; a++) begin
            for (int j = 0; j < n - 1 - a; j++) begin
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
            end
        end
        for (int i = 0; i < n; i++) begin
            b.k   = req;
            b.d   = s[i];
            b.sop = (i == 0);
            b.eop = (i == n - 1);
            exp_res_q.push_back(b);
        end
        exp_owner_q.push_back(req);
    endtask

    task automatic queue_stray(input int req, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.k = req; b.d = 8'(8'hA0 + i); b.sop = 1'b0; b.eop = 1'b0;
            tx_q.push_back(b);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk_i);
            #1;
            if (tx_q.size() == 0 && exp_res_q.size() == 0 && eng_out_q.size() == 0 && !busy_o)
                done = 1'b1;
        end
        check_eq(tag, 32'(done), 1);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk_i);
        #2 arstn_i = 1'b0;
        #1;
        check_eq({tag, "_busy"}, 32'(busy_o), 0);
        check_eq({tag, "_owner"}, 32'(owner_o), 0);
        check_eq({tag, "_eng_valid"}, 32'(eng_valid_o), 0);
        check_eq({tag, "_res_valid"}, 32'(res_valid_o), 0);
        check_eq({tag, "_eng_ready"}, 32'(eng_ready_o), 0);
        check_eq({tag, "_drop"}, 32'(drop_cnt_o), 0);
        @(negedge clk_i);
        @(negedge clk_i);
        #1 arstn_i = 1'b1;
    endtask

    // Requester and engine agent: drive on the falling edge, sample just before the rising edge.
    initial begin
        logic [3:0] fire_req;
        logic       eng_fire;
        int         idx;
        beat_t      e;
        logic [3:0] onehot;
        forever begin
            @(negedge clk_i);
            if (!arstn_i) begin
                tx_q.delete(); exp_res_q.delete(); eng_out_q.delete();
                exp_owner_q.delete(); pkt_buf.delete();
                feeding = 1'b0; cur_owner = -1; stall_left = 0;
            end
            for (int k = 0; k < 4; k++) begin
                idx = first_idx(k);
                req_valid_i[k]         = (idx >= 0);
                req_data_i[k*8 +: 8]   = (idx >= 0) ? tx_q[idx].d : 8'h00;
                req_startofpacket_i[k] = (idx >= 0) ? tx_q[idx].sop : 1'b0;
                req_endofpacket_i[k]   = (idx >= 0) ? tx_q[idx].eop : 1'b0;
            end
            tog         = ~tog;
            eng_ready_i = bp ? tog : 1'b1;
            eng_valid_i = (eng_out_q.size() > 0);
            if (eng_valid_i) begin
                eng_data_i          = eng_out_q[0].d;
                eng_startofpacket_i = eng_out_q[0].sop;
                eng_endofpacket_i   = eng_out_q[0].eop;
            end else begin
                eng_data_i = '0; eng_startofpacket_i = 1'b0; eng_endofpacket_i = 1'b0;
            end
            res_ready_i = (stall_left > 0) ? 4'b0000 : 4'b1111;
            #4;
            if (arstn_i) begin
                fire_req = req_valid_i & req_ready_o;
                eng_fire = eng_valid_o && eng_ready_i;
                if (eng_fire) begin
                    if (!feeding) begin
                        cur_owner = (exp_owner_q.size() > 0) ? exp_owner_q.pop_front() : -1;
                        check_eq("grant_owner", 32'(owner_o), cur_owner);
                        feeding = 1'b1;
                    end
                    idx = first_idx(cur_owner);
                    check_eq("feed_src_known", 32'(idx >= 0), 1);
                    if (idx >= 0) begin
                        check_eq("feed_data", 32'(eng_data_o), 32'(tx_q[idx].d));
                        check_eq("feed_sop", 32'(eng_startofpacket_o), 32'(tx_q[idx].sop));
                        check_eq("feed_eop", 32'(eng_endofpacket_o), 32'(tx_q[idx].eop));
                    end
                    onehot = 4'b0001 << cur_owner;
                    check_eq("feed_ready", 32'(fire_req), 32'(onehot));
                    pkt_buf.push_back(eng_data_o);
                    if (eng_endofpacket_o) begin
                        feeding = 1'b0;
                        pkt_buf.sort();
                        for (int i = 0; i < pkt_buf.size(); i++) begin
                            e.k = cur_owner; e.d = pkt_buf[i];
                            e.sop = (i == 0); e.eop = (i == pkt_buf.size() - 1);
                            eng_out_q.push_back(e);
                        end
                        pkt_buf.delete();
                    end
                end
                for (int k = 0; k < 4; k++) begin
                    if (fire_req[k]) begin
                        idx = first_idx(k);
                        check_eq("fire_known", 32'(idx >= 0), 1);
                        if (idx >= 0) begin
                            if (!(eng_fire && k == cur_owner)) begin
                                check_eq("stray_sop", 32'(tx_q[idx].sop), 0);
                                stray_cnt++;
                            end
                            tx_q.delete(idx);
                        end
                    end
                end
                if (eng_valid_i) begin
                    check_eq("res_pending", 32'(exp_res_q.size() > 0), 1);
                    if (exp_res_q.size() > 0) begin
                        e      = exp_res_q[0];
                        onehot = 4'b0001 << e.k;
                        check_eq("res_valid_onehot", 32'(res_valid_o), 32'(onehot));
                        check_eq("eng_ready_mirror", 32'(eng_ready_o), 32'(res_ready_i[e.k]));
                        if (eng_ready_o) begin
                            check_eq("res_data", 32'(res_data_o), 32'(e.d));
                            check_eq("res_sop", 32'(res_startofpacket_o), 32'(e.sop));
                            check_eq("res_eop", 32'(res_endofpacket_o), 32'(e.eop));
                            void'(exp_res_q.pop_front());
                        end
                    end
                    if (eng_ready_o) void'(eng_out_q.pop_front());
                    if (stall_left > 0) stall_left--;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk_i);
        #1;
        check_eq("rst_busy", 32'(busy_o), 0);
        check_eq("rst_owner", 32'(owner_o), 0);
        check_eq("rst_drop", 32'(drop_cnt_o), 0);
        check_eq("rst_req_ready", 32'(req_ready_o), 0);
        check_eq("rst_eng_valid", 32'(eng_valid_o), 0);
        check_eq("rst_res_valid", 32'(res_valid_o), 0);
        check_eq("rst_eng_ready", 32'(eng_ready_o), 0);
        check_eq("rst_eng_data", 32'(eng_data_o), 0);
        arstn_i = 1'b1;

        // Single requester 2: [5,3,9] -> [3,5,9]
        @(negedge clk_i); #1;
        queue_pkt(2, 3, {8'h00, 8'd9, 8'd3, 8'd5});
        wait_idle("single_done", 60);
        check_eq("single_owner", 32'(owner_o), 2);

        // Stray beats on requester 1 while idle
        stray_cnt = 0;
        queue_stray(1, 3);
        wait_idle("stray_done", 30);
        check_eq("stray_accepted", stray_cnt, 3);
        check_eq("stray_drop_cnt", 32'(drop_cnt_o), 3);
        check_eq("stray_no_grant", 32'(busy_o), 0);
        check_eq("stray_owner_kept", 32'(owner_o), 2);

        // All four contend right after reset: grants 0,1,2,3
        do_reset("rst_a");
        queue_pkt(0, 2, {16'h0000, 8'd1, 8'd2});
        queue_pkt(1, 3, {8'h00, 8'd7, 8'd8, 8'd6});
        queue_pkt(2, 4, {8'd4, 8'd3, 8'd2, 8'd1});
        queue_pkt(3, 3, {8'h00, 8'hFF, 8'h00, 8'h80});
        wait_idle("contend_done", 200);
        check_eq("contend_last_owner", 32'(owner_o), 3);

        // Back-pressure on both sides
        bp = 1'b1;
        stall_left = 3;
        queue_pkt(3, 4, {8'd20, 8'd30, 8'd10, 8'd40});
        wait_idle("bp_done", 200);
        bp = 1'b0;

        // Single-beat packet
        queue_pkt(0, 1, 32'h0000_007F);
        wait_idle("onebeat_done", 40);
        check_eq("onebeat_owner", 32'(owner_o), 0);

        // Reset in the middle of a feed, then requester 0 wins again
        bp = 1'b1;
        queue_pkt(2, 4, {8'd4, 8'd3, 8'd2, 8'd1});
        for (int i = 0; i < 40 && !busy_o; i++) begin
            @(negedge clk_i); #1;
        end
        check_eq("midfeed_busy", 32'(busy_o), 1);
        do_reset("rst_mid");
        bp = 1'b0;
        queue_pkt(0, 2, {16'h0000, 8'd2, 8'd6});
        queue_pkt(1, 2, {16'h0000, 8'd1, 8'd8});
        wait_idle("post_reset_done", 100);
        check_eq("post_reset_owner", 32'(owner_o), 1);
        check_eq("leftover", tx_q.size() + exp_res_q.size() + eng_out_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sort_arbiter.md
# sort_arbiter

Packet-granular round-robin scheduler that shares one `sort` engine between `N_REQ` Avalon-ST requesters. It grants one requester a whole packet at a time and forwards it to the engine's sink. It then routes the engine's sorted output packet back to that same requester before issuing the next grant. It sits between the requester interfaces and the single sort engine instance.

## Interface
- `N_REQ`, 4, number of requesters (≥2)
- `DWIDTH`, 8, data word width; must match the engine
- `IDX_W`, `$clog2(N_REQ)`, localparam, owner index width
- `clk_i` in 1 clock
- `arstn_i` in 1 — one clock; reset is asynchronous and active-low
- `req_data_i` in `N_REQ*DWIDTH` requester data, requester k at bits `[k*DWIDTH +: DWIDTH]`
- `req_startofpacket_i` / `req_endofpacket_i` / `req_valid_i` in `N_REQ` each, per-requester framing and valid
- `req_ready_o` out `N_REQ` per-requester ready
- `eng_data_o` out `DWIDTH`, `eng_startofpacket_o`, `eng_endofpacket_o`, `eng_valid_o` out 1 each — to engine sink
- `eng_ready_i` in 1 engine sink ready
- `eng_data_i` in `DWIDTH`, `eng_startofpacket_i`, `eng_endofpacket_i`, `eng_valid_i` in 1 each — from engine source
- `eng_ready_o` out 1 to engine source ready
- `res_data_o` out `DWIDTH`, `res_startofpacket_o`, `res_endofpacket_o` out 1 each — shared result bus
- `res_valid_o` out `N_REQ` one-hot result valid
- `res_ready_i` in `N_REQ` per-requester result ready
- `owner_o` out `IDX_W` current or last owner
- `busy_o` out 1, high in FEED_S or RESULT_S
- `drop_cnt_o` out 16 saturating count of discarded out-of-packet beats

## Operation
- A beat transfers on any interface when valid && ready in the same cycle.
- States: IDLE_S, FEED_S, RESULT_S.
- **IDLE_S**
  - A requester is eligible when `req_valid_i[k] && req_startofpacket_i[k]`.
  - The round-robin pick starts at `(last_owner+1) mod N_REQ`. The winner is registered into `owner_o` and the state moves to FEED_S.
  - No beat is accepted in the grant cycle.
  - Any valid beat with SOP=0 is accepted and dropped (`req_ready_o[k]=1`), and `drop_cnt_o` increments by one per cycle in which at least one such beat occurs, saturating at 0xFFFF.
- **FEED_S**
  - Combinational pass-through from the owner: `eng_*_o` = owner's data/sop/eop/valid, and `req_ready_o[owner]=eng_ready_i`. All other `req_ready_o` are 0.
  - An accepted beat with EOP goes to RESULT_S. A single-beat packet (SOP and EOP together) goes straight to RESULT_S.
  - A mid-packet SOP is forwarded unchanged; the block does not repair framing.
  - `eng_ready_o=0`.
- **RESULT_S**
  - `eng_valid_o=0`.
  - `res_data_o`/sop/eop follow the `eng_*_i` inputs. `res_valid_o[owner]=eng_valid_i` and the other bits are 0. `eng_ready_o=res_ready_i[owner]`.
  - An accepted beat with EOP goes to IDLE_S, and `last_owner` ← `owner`.
- Outside RESULT_S, `eng_ready_o=0` and the engine output is back-pressured.

## Timing
- Reset values: state IDLE_S, `owner_o=0`, `last_owner=N_REQ-1` (so requester 0 has first priority), `drop_cnt_o=0`. All valid/ready/sop/eop outputs are 0. `busy_o=0`.
- Data/sop/eop outputs with no valid are don't-care but are driven to 0.
- Reset is asserted asynchronously, takes effect at any state, and discards any packet in flight. The engine must be reset alongside.
- Grant latency: an eligible SOP at cycle t is granted at the edge ending cycle t. The first beat can transfer at t+1.
- Turnaround: a result EOP accepted at cycle t gives IDLE_S at t+1. The earliest next grant is at the edge ending t+1 and the next feed beat at t+2.
- All data paths are zero-latency combinational muxes; only the state, owner, pointer and counter are registered.
- Requests that arrive during FEED_S or RESULT_S wait; `req_ready_o=0` for them.

## Structure
- Package `sort_pkg` holds the state enum `arb_state_t` and the `DWIDTH` default.
- Sub-module `rr_pick`: combinational round-robin picker taking `N_REQ` request bits and a pointer, producing a grant index and any-grant.
- The FSM, muxes and counter live in `sort_arbiter`.

## Test plan
- **Single requester:** only requester 2 sends [5,3,9] and the engine model returns [3,5,9]. Required: `owner_o=2`, `eng_*` carry 5,3,9 with SOP on 5 and EOP on 9, `res_valid_o=4'b0100` with 3,5,9, and IDLE_S afterwards.
- **All contend:** all 4 requesters raise SOP at the same cycle after reset. Required grant order is 0,1,2,3, with each result routed only to its owner.
- **Back-pressure:** `eng_ready_i` toggles 1/0 during feed and `res_ready_i[owner]` is held 0 for 3 cycles. Required: no beat lost or duplicated, and `eng_ready_o` mirrors `res_ready_i[owner]`.
- **Stray beats:** requester 1 sends 3 valid beats with SOP=0 while in IDLE_S. Required: each is accepted, `drop_cnt_o=3`, and no grant is issued.
- **Single-beat packet:** SOP and EOP set on the same beat with value 0x7F. Required: FEED_S lasts one beat and RESULT_S returns 0x7F with SOP and EOP set.
- **Reset mid-feed:** `arstn_i` pulses low during FEED_S. Required: outputs drop to reset values immediately and requester 0 has priority again.
